pong_serve_ctrl: RTL and testbench

- Frame-based serve sequencer for the Pong game-logic section.
- Decides when the ball is hidden, held, or in play after a coin start or a miss.
- Drives the gating inputs of the ball/score NOR-gate logic (ball_en, serve_hold_n, attract).
- Sits between the video timing chain (frame strobe), the score/miss detectors and the ball motion counters.

---
 rtl/pong_serve_ctrl.sv | 109 ++++++++++
 tb/tb_pong_serve_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pong_serve_ctrl.sv
// Frame-based serve sequencer for the Pong game logic: hides, holds and releases the ball.
// Optional build macro PONG_SERVE_ALTERNATE_EN: alternate serve direction on every miss.
module pong_serve_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             miss,
  input  logic             miss_side,
  input  logic             game_over,
  output logic             ball_en,
  output logic             serve_hold_n,
  output logic             attract,
  output logic             serve_side,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    ATTRACT = 2'd0,
    HOLD    = 2'd1,
    PLAY    = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t state;
  logic   game_over_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LAST) ? LAST : v + 1'b1;
  endfunction

  function automatic logic next_side(input logic cur, input logic missed);
`ifdef PONG_SERVE_ALTERNATE_EN
    next_side = ~cur;
    if (missed) next_side = ~cur;
`else
    next_side = missed;
    if (cur) next_side = missed;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ATTRACT;
      attract      <= 1'b1;
      ball_en      <= 1'b1;
      serve_hold_n <= 1'b1;
      serve_side   <= 1'b0;
      hold_cnt     <= '0;
      game_over_q  <= 1'b0;
    end else begin
      game_over_q <= game_over;
      case (state)
        ATTRACT, OVER: begin
          // start outranks a coincident miss; misses never matter here
          if (start) begin
            state        <= HOLD;
            attract      <= 1'b0;
            ball_en      <= 1'b0;
            serve_hold_n <= 1'b0;
            serve_side   <= 1'b0;
            hold_cnt     <= '0;
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt >= LAST) begin
              state        <= PLAY;
              ball_en      <= 1'b1;
              serve_hold_n <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= sat_inc(hold_cnt);
            end
          end
        end
        PLAY: begin
          if (miss && game_over) begin
            state   <= OVER;
            attract <= 1'b1;
          end else if (miss) begin
            state        <= HOLD;
            ball_en      <= 1'b0;
            serve_hold_n <= 1'b0;
            hold_cnt     <= '0;
            serve_side   <= next_side(serve_side, miss_side);
          end else if (game_over && !game_over_q) begin
            state   <= OVER;
            attract <= 1'b1;
          end
        end
        default: begin
          state        <= ATTRACT;
          attract      <= 1'b1;
          ball_en      <= 1'b1;
          serve_hold_n <= 1'b1;
          serve_side   <= 1'b0;
          hold_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_serve_ctrl.sv
// Self-checking bench for pong_serve_ctrl: vector table, reset sequences, randomized model compare.
module tb_pong_serve_ctrl;

  localparam int SF = 4;
  localparam int CW = 8;
`ifdef PONG_SERVE_ALTERNATE_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  localparam int P_ATTRACT = 0;
  localparam int P_HOLD    = 1;
  localparam int P_PLAY    = 2;
  localparam int P_OVER    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0, start = 1'b0, miss = 1'b0, miss_side = 1'b0, game_over = 1'b0;
  logic          ball_en, serve_hold_n, attract, serve_side;
  logic [CW-1:0] hold_cnt;

  int checks = 0;
  int failures = 0;

  pong_serve_ctrl #(.SERVE_FRAMES(SF), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .miss(miss),
    .miss_side(miss_side), .game_over(game_over), .ball_en(ball_en),
    .serve_hold_n(serve_hold_n), .attract(attract), .serve_side(serve_side), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, ms, sd, go, ft;
    logic at, be, shn, ss;
    int   cnt;
  } vec_t;
  vec_t tbl[$];

  // Reference model: game phase plus number of frames already hidden
  int m_phase, m_hidden;
  bit m_side, m_go_prev;

  function automatic void model_reset();
    m_phase = P_ATTRACT; m_hidden = 0; m_side = 1'b0; m_go_prev = 1'b0;
  endfunction

  function automatic void model_step(bit st, bit ms, bit sd, bit go, bit ft);
    bit rise = go && !m_go_prev;
    m_go_prev = go;
    if (m_phase == P_ATTRACT || m_phase == P_OVER) begin
      if (st) begin m_phase = P_HOLD; m_hidden = 0; m_side = 1'b0; end
    end else if (m_phase == P_HOLD) begin
      if (ft) m_hidden = m_hidden + 1;
      if (m_hidden == SF) begin m_phase = P_PLAY; m_hidden = 0; end
    end else begin
      if (ms && go) m_phase = P_OVER;
      else if (ms) begin
        m_phase = P_HOLD; m_hidden = 0;
        m_side = ALT ? !m_side : sd;
      end else if (rise) m_phase = P_OVER;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit at, input bit be, input bit shn,
                         input bit ss, input int cnt);
    chk({tag, ".attract"}, int'(attract), int'(at));
    chk({tag, ".ball_en"}, int'(ball_en), int'(be));
    chk({tag, ".serve_hold_n"}, int'(serve_hold_n), int'(shn));
    chk({tag, ".serve_side"}, int'(serve_side), int'(ss));
    chk({tag, ".hold_cnt"}, int'(hold_cnt), cnt);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, (m_phase == P_ATTRACT || m_phase == P_OVER), (m_phase != P_HOLD),
            (m_phase != P_HOLD), m_side, (m_phase == P_HOLD) ? m_hidden : 0);
  endtask

  task automatic drive(input bit st, input bit ms, input bit sd, input bit go, input bit ft);
    @(negedge clk);
    start = st; miss = ms; miss_side = sd; game_over = go; frame_tick = ft;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit st, input bit ms, input bit sd, input bit go, input bit ft,
                     input bit at, input bit be, input bit shn, input bit ss, input int cnt);
    vec_t v;
    v.st = st; v.ms = ms; v.sd = sd; v.go = go; v.ft = ft;
    v.at = at; v.be = be; v.shn = shn; v.ss = ss; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    bit s14;
    bit go_r;
    s14 = ALT ? 1'b0 : 1'b1;

    //   st ms sd go ft | at be shn ss cnt
    add(0, 0, 0, 0, 0,  1, 1, 1, 0, 0);   // idle attract
    add(0, 1, 1, 0, 0,  1, 1, 1, 0, 0);   // miss ignored in attract
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);   // start -> hold
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 1,  0, 0, 0, 0, 2);   // start/miss ignored, tick counted
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 3);   // still hidden at SF-1
    add(0, 0, 0, 0, 1,  0, 1, 1, 0, 0);   // 4th tick releases
    add(0, 1, 1, 0, 1,  0, 0, 0, 1, 0);   // miss + tick in play: hold, cnt 0
    add(0, 0, 0, 0, 1,  0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1,  0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1,  0, 1, 1, 1, 0);
    add(0, 1, 1, 0, 0,  0, 0, 0, s14, 0); // second right-side miss
    add(0, 0, 0, 0, 1,  0, 0, 0, s14, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, s14, 2);
    add(0, 0, 0, 0, 1,  0, 0, 0, s14, 3);
    add(0, 0, 0, 0, 1,  0, 1, 1, s14, 0);
    add(0, 1, 0, 1, 0,  1, 1, 1, s14, 0); // miss with game_over -> over
    add(0, 1, 1, 1, 0,  1, 1, 1, s14, 0); // later miss ignored
    add(1, 1, 1, 0, 0,  0, 0, 0, 0, 0);   // start beats miss, side cleared
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1,  0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0,  1, 1, 1, 0, 0);   // game_over rising in play
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    rst_n = 1'b0;
    #12;
    chk_all("reset", 1, 1, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].ms, tbl[i].sd, tbl[i].go, tbl[i].ft);
      chk_all($sformatf("vec%0d", i), tbl[i].at, tbl[i].be, tbl[i].shn, tbl[i].ss, tbl[i].cnt);
    end

    // Asynchronous reset mid-HOLD at hold_cnt=2, checked before the next edge
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk_all("pre_rst_hold", 0, 0, 0, 0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1, 1, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    chk_all("post_rst_idle", 1, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk_all("restart", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk_all("restart_tick", 0, 0, 0, 0, 1);

    // Randomized run against the reference model
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; miss = 0; frame_tick = 0; game_over = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    go_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      bit st, ms, sd, ft;
      st = ($urandom_range(0, 19) == 0);
      ms = ($urandom_range(0, 11) == 0);
      sd = 1'($urandom);
      ft = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) go_r = !go_r;
      drive(st, ms, sd, go_r, ft);
      model_step(st, ms, sd, go_r, ft);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
